// File: rtl/aes_stream_loader.sv
// aes_stream_loader: writes host words (in_*) into the AES buffer (mem_*) zero-padded and sentinel-terminated, runs the engine (aes_*), streams results back (out_*), status busy/done/err
module aes_stream_loader #(
  parameter logic [9:0]  IN_BASE    = 10'd0,
  parameter logic [9:0]  OUT_BASE   = 10'd257,
  parameter int          MAX_WORDS  = 252,
  parameter int          RD_LATENCY = 2,
  parameter logic [31:0] SENTINEL   = 32'hDEADBEEF
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        start_in,
  input  logic        mode_in,
  input  logic [31:0] in_data_in,
  input  logic        in_valid_in,
  input  logic        in_last_in,
  output logic        in_ready_out,
  output logic [3:0]  mem_we_out,
  output logic [9:0]  mem_addr_out,
  output logic [31:0] mem_wdata_out,
  input  logic [31:0] mem_rdata_in,
  output logic [2:0]  aes_ctrl_out,
  input  logic        aes_complete_in,
  output logic [31:0] out_data_out,
  output logic        out_valid_out,
  output logic        out_last_out,
  input  logic        out_ready_in,
  output logic        busy_out,
  output logic        done_out,
  output logic        err_out
);
  localparam logic [9:0] MAX_W     = 10'(MAX_WORDS);
  localparam logic [3:0] WAIT_LAST = 4'(RD_LATENCY - 1);
  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_PAD, S_TERM, S_RUN, S_ADDR, S_WAIT, S_PRES, S_DONE
  } state_t;
  state_t      state_q, state_d;
  logic [9:0]  wcnt_q, wcnt_d, rcnt_q, rcnt_d;
  logic [3:0]  wait_q, wait_d;
  logic [31:0] data_q, data_d;
  logic        mode_q, mode_d, err_q, err_d;
  logic [9:0]  wcnt_inc;
  logic        is_last;
  assign wcnt_inc = wcnt_q + 10'd1;
  assign is_last  = rcnt_q == wcnt_q - 10'd1;

  always_ff @(posedge clk_in or posedge rst_in)
    if (rst_in) begin
      state_q <= S_IDLE;
      wcnt_q  <= '0;
      rcnt_q  <= '0;
      wait_q  <= '0;
      data_q  <= '0;
      mode_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      rcnt_q  <= rcnt_d;
      wait_q  <= wait_d;
      data_q  <= data_d;
      mode_q  <= mode_d;
      err_q   <= err_d;
    end

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    rcnt_d  = rcnt_q;
    wait_d  = wait_q;
    data_d  = data_q;
    mode_d  = mode_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: if (start_in) begin
        state_d = S_LOAD;
        mode_d  = mode_in;
        wcnt_d  = '0;
        rcnt_d  = '0;
        err_d   = 1'b0;
      end
      S_LOAD: if (in_valid_in) begin
        wcnt_d  = wcnt_inc;
        err_d   = err_q | (in_data_in == SENTINEL) | (!in_last_in && wcnt_inc == MAX_W);
        state_d = (in_last_in || wcnt_inc == MAX_W) ? (wcnt_inc[1:0] != 2'd0 ? S_PAD : S_TERM) : S_LOAD;
      end
      S_PAD: begin
        wcnt_d  = wcnt_inc;
        state_d = wcnt_inc[1:0] == 2'd0 ? S_TERM : S_PAD;
      end
      S_TERM: state_d = S_RUN;
      S_RUN:  state_d = aes_complete_in ? S_ADDR : S_RUN;
      S_ADDR: begin
        state_d = S_WAIT;
        wait_d  = '0;
      end
      S_WAIT: if (wait_q == WAIT_LAST) begin
        data_d  = mem_rdata_in == SENTINEL ? data_q : mem_rdata_in;
        err_d   = err_q | (mem_rdata_in == SENTINEL);
        state_d = mem_rdata_in == SENTINEL ? S_DONE : S_PRES;
      end else wait_d = wait_q + 4'd1;
      S_PRES: if (out_ready_in) begin
        rcnt_d  = rcnt_q + 10'd1;
        state_d = is_last ? S_DONE : S_ADDR;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready_out  = state_q == S_LOAD;
    mem_we_out    = ((state_q == S_LOAD && in_valid_in) || state_q == S_PAD || state_q == S_TERM) ? 4'hF : 4'h0;
    mem_addr_out  = (state_q == S_ADDR || state_q == S_WAIT) ? OUT_BASE + rcnt_q :
                    (state_q == S_LOAD || state_q == S_PAD || state_q == S_TERM) ? IN_BASE + wcnt_q : 10'd0;
    mem_wdata_out = state_q == S_LOAD ? in_data_in : state_q == S_TERM ? SENTINEL : 32'd0;
    aes_ctrl_out  = state_q == S_RUN ? (mode_q ? 3'b010 : 3'b001) : 3'b000;
    out_data_out  = data_q;
    out_valid_out = state_q == S_PRES;
    out_last_out  = state_q == S_PRES && is_last;
    busy_out      = state_q != S_IDLE;
    done_out      = state_q == S_DONE;
    err_out       = err_q;
  end
endmodule

// File: doc/aes_stream_loader.md
Name: aes_stream_loader

Overview:
- Host-side front end for the AES engine's shared 1024x32 buffer memory.
- Accepts a plaintext or ciphertext word stream over valid/ready and writes it to the input region from word address 0, zero-padded to whole 128-bit blocks and terminated by the sentinel.
- Drives the AES control word and waits for completion.
- Reads the processed words back from the output region and streams them to the host over valid/ready.

Parameters:
- IN_BASE, 0, word address of first input word.
- OUT_BASE, 257, word address of first result word.
- MAX_WORDS, 252, maximum payload words per job; multiple of 4.
- RD_LATENCY, 2, memory read latency in cycles (address to data).
- SENTINEL, 32'hDEADBEEF, end-of-data marker.

Ports:
- clk_in  input  1  clock.
- rst_in  input  1  asynchronous active-high reset.
- start_in  input  1  one-cycle job start pulse; honoured only in IDLE.
- mode_in  input  1  0 = encrypt, 1 = decrypt; sampled with start_in.
- in_data_in  input  32  payload word.
- in_valid_in  input  1  payload word valid.
- in_last_in  input  1  marks final payload word.
- in_ready_out  output  1  loader accepts payload.
- mem_we_out  output  4  byte write enables to buffer memory.
- mem_addr_out  output  10  buffer memory address, shared by reads and writes.
- mem_wdata_out  output  32  buffer write data.
- mem_rdata_in  input  32  buffer read data.
- aes_ctrl_out  output  3  AES control word: bit0 = encrypt, bit1 = decrypt, bit2 = 0.
- aes_complete_in  input  1  AES engine finished writeback.
- out_data_out  output  32  result word.
- out_valid_out  output  1  result word valid.
- out_last_out  output  1  marks final result word.
- out_ready_in  input  1  host accepts result.
- busy_out  output  1  high in every state except IDLE.
- done_out  output  1  one-cycle pulse at job end.
- err_out  output  1  sticky error; cleared on next accepted start_in.

Behaviour:
- Reset (async, immediate) drives all outputs to 0, state to IDLE and all counters to 0.
- IDLE:
  - On start_in, latch mode, clear wcnt/rcnt/err_out, go to LOAD.
  - start_in in any other state is ignored.
- LOAD:
  - in_ready_out = 1, combinational from state.
  - On a handshake, write in_data_in to IN_BASE+wcnt with mem_we_out = 4'hF, then wcnt++.
  - A payload word equal to SENTINEL is still written, and err_out is set (engine will truncate).
  - Leave LOAD on a handshake with in_last_in = 1, or when wcnt reaches MAX_WORDS (overflow without last: set err_out; later words stay unaccepted).
  - Next state is PAD if wcnt%4 != 0, otherwise TERM.
- PAD: write 0 at IN_BASE+wcnt, one word per cycle, wcnt++, until wcnt%4 == 0; then TERM.
- TERM: write SENTINEL at IN_BASE+wcnt for one cycle; go to RUN.
- RUN:
  - mem_we_out = 0, the memory port is owned by the engine, and aes_ctrl_out = mode ? 3'b010 : 3'b001.
  - On the first cycle aes_complete_in = 1, go to DRAIN with aes_ctrl_out = 0 on the next cycle; the control word is never held past completion.
  - No timeout.
- DRAIN (substates ADDR, WAIT, PRESENT):
  - ADDR: drive mem_addr_out = OUT_BASE+rcnt.
  - WAIT: RD_LATENCY cycles; capture mem_rdata_in into out_data_out.
  - PRESENT: out_valid_out = 1; out_last_out = (rcnt == wcnt-1). Data, valid and last stay stable until out_ready_in.
  - On a handshake: rcnt++; go to DONE if last, otherwise back to ADDR.
  - A captured SENTINEL before rcnt == wcnt sets err_out, goes straight to DONE and is not presented.
- DONE: done_out = 1 for one cycle, busy_out falls; go to IDLE.
- Memory address width: all address adds are 10-bit; MAX_WORDS guarantees IN_BASE+MAX_WORDS < OUT_BASE.

Test Plan:
- Encrypt job, 4 words 0x00112233, 0x44556677, 0x8899AABB, 0xCCDDEEFF with last on the 4th:
  - Writes go to addresses 0..3.
  - SENTINEL is written at 4.
  - aes_ctrl_out = 3'b001 until complete.
  - With an engine model, 4 result words are read from 257..260; out_last_out is on the 4th; done_out pulses once.
- 5-word job:
  - Zeros are written at 5, 6, 7 and SENTINEL at 8.
  - 8 result words stream out, out_last_out on the 8th.
- Decrypt mode with out_ready_in toggled 1-0-0-1 on every word: aes_ctrl_out = 3'b010; out_data_out/out_last_out stay stable while out_ready_in = 0; no word is lost or duplicated.
- 252 words without in_last_in:
  - in_ready_out drops after word 252.
  - SENTINEL is written at 252 and err_out = 1.
  - 252 results are returned.
- Payload word 0xDEADBEEF at position 2: err_out = 1, and the job still completes through done_out.
- rst_in asserted mid-RUN: aes_ctrl_out, busy_out and mem_we_out go to 0 without waiting for a clock edge; a new start_in then runs a clean job.
